// File: rtl/axi_burst_injector_if.sv
// AXI4 manager-side bus bundle for the burst injector (AW/W/B/AR/R channels).
// The master modport is the injector's view; the slave modport is the fabric's view.
interface axi_burst_injector_if #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 48,
    parameter int ID_WIDTH   = 24
) ();
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic                    arvalid;
    logic                    arready;

    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arprot, arqos, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arprot, arqos, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_burst_injector.sv
// Single-burst AXI4 traffic injector: one INCR write or read per command, seeded data pattern.
// Define AXI_BURST_INJECTOR_READ_CHECK_EN to compare read data against the pattern.
//
// state      | meaning
// IDLE       | waiting for a command, cmd_ready high
// WRITE      | AW and W issued independently until both complete
// WRITE_RESP | waiting for B response
// READ_ADDR  | AR issued until accepted
// READ_DATA  | consuming R beats
// DONE       | one-cycle completion pulse
module axi_burst_injector #(
    parameter int          DATA_WIDTH = 256,
    parameter int          ADDR_WIDTH = 48,
    parameter int          ID_WIDTH   = 24,
    parameter logic [3:0]  QOS        = 4'd0
) (
    input  logic                  aclock,
    input  logic                  areset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ID_WIDTH-1:0]   cmd_id,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_prot,
    input  logic [31:0]           cmd_seed,
    output logic                  done_pulse,
    output logic                  done_error,
    output logic [15:0]           mismatch_count,
    output logic                  busy,
    axi_burst_injector_if.master  axi
);
    localparam logic [2:0] BEAT_SIZE = 3'($clog2(DATA_WIDTH/8));

    typedef enum logic [2:0] {IDLE, WRITE, WRITE_RESP, READ_ADDR, READ_DATA, DONE} state_t;

    state_t                state, state_nxt;
    logic                  write_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [2:0]            prot_q;
    logic [31:0]           seed_q;
    logic [7:0]            beat_cnt;
    logic                  aw_done, w_done, err_q;
    logic                  accept, aw_hs, w_hs, last_beat, beat_mismatch;
    logic [31:0]           cur_word;

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [31:0] word);
        return {(DATA_WIDTH/32){word}};
    endfunction

    assign accept    = cmd_valid & cmd_ready;
    assign aw_hs     = axi.awvalid & axi.awready;
    assign w_hs      = axi.wvalid & axi.wready;
    assign last_beat = (beat_cnt == len_q);
    assign cur_word  = seed_q + {24'd0, beat_cnt};

    assign axi.awid    = id_q;
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = len_q;
    assign axi.awsize  = BEAT_SIZE;
    assign axi.awburst = 2'b01;
    assign axi.awprot  = prot_q;
    assign axi.awqos   = QOS;
    assign axi.wdata   = pattern(cur_word);
    assign axi.wstrb   = '1;
    assign axi.wlast   = last_beat;
    assign axi.arid    = id_q;
    assign axi.araddr  = addr_q;
    assign axi.arlen   = len_q;
    assign axi.arsize  = BEAT_SIZE;
    assign axi.arburst = 2'b01;
    assign axi.arprot  = prot_q;
    assign axi.arqos   = QOS;

    assign busy       = (state != IDLE);
    assign done_error = (state == DONE) & err_q;

    always_comb begin
        state_nxt   = state;
        cmd_ready   = 1'b0;
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        axi.bready  = 1'b0;
        axi.arvalid = 1'b0;
        axi.rready  = 1'b0;
        done_pulse  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = ~areset;
                if (cmd_valid && !areset)
                    state_nxt = cmd_write ? WRITE : READ_ADDR;
            end
            WRITE: begin
                axi.awvalid = ~aw_done;
                axi.wvalid  = ~w_done;
                if ((aw_done || aw_hs) && (w_done || (w_hs && last_beat)))
                    state_nxt = WRITE_RESP;
            end
            WRITE_RESP: begin
                axi.bready = 1'b1;
                if (axi.bvalid)
                    state_nxt = DONE;
            end
            READ_ADDR: begin
                axi.arvalid = 1'b1;
                if (axi.arready)
                    state_nxt = READ_DATA;
            end
            READ_DATA: begin
                axi.rready = 1'b1;
                if (axi.rvalid && (axi.rlast || last_beat))
                    state_nxt = DONE;
            end
            DONE: begin
                done_pulse = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclock) begin
        if (areset) begin
            state    <= IDLE;
            write_q  <= 1'b0;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            prot_q   <= '0;
            seed_q   <= '0;
            beat_cnt <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                write_q  <= cmd_write;
                id_q     <= cmd_id;
                addr_q   <= cmd_addr;
                len_q    <= cmd_len;
                prot_q   <= cmd_prot;
                seed_q   <= cmd_seed;
                beat_cnt <= '0;
                aw_done  <= 1'b0;
                w_done   <= 1'b0;
                err_q    <= 1'b0;
            end
            if (state == WRITE) begin
                if (aw_hs)
                    aw_done <= 1'b1;
                if (w_hs) begin
                    if (last_beat)
                        w_done <= 1'b1;
                    else
                        beat_cnt <= beat_cnt + 8'd1;
                end
            end
            if (state == WRITE_RESP && axi.bvalid)
                err_q <= err_q | (axi.bresp != 2'b00) | (axi.bid != id_q);
            // rlast and the local count must agree; either one ends the burst
            if (state == READ_DATA && axi.rvalid) begin
                err_q <= err_q | (axi.rresp != 2'b00) | (axi.rid != id_q)
                         | (axi.rlast != last_beat) | beat_mismatch;
                if (!(axi.rlast || last_beat))
                    beat_cnt <= beat_cnt + 8'd1;
            end
        end
    end

`ifdef AXI_BURST_INJECTOR_READ_CHECK_EN
    logic [15:0] mm_cnt;

    assign beat_mismatch  = (axi.rdata != pattern(cur_word));
    assign mismatch_count = mm_cnt;

    always_ff @(posedge aclock) begin
        if (areset || accept)
            mm_cnt <= '0;
        else if (state == READ_DATA && axi.rvalid && beat_mismatch && mm_cnt != 16'hFFFF)
            mm_cnt <= mm_cnt + 16'd1;
    end
`else
    logic unused_rdata;

    assign beat_mismatch  = 1'b0;
    assign mismatch_count = 16'd0;
    assign unused_rdata   = ^{axi.rdata, write_q};
`endif

endmodule

// File: tb/tb_axi_burst_injector.sv
// Directed bench for axi_burst_injector: reactive AXI slave model at negedge,
// command sequences with hand-computed expectations checked at negedge+1.
module tb_axi_burst_injector;
    localparam int DW = 256;
    localparam int AW = 48;
    localparam int IW = 24;

    logic          aclock, areset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [IW-1:0] cmd_id;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic [2:0]    cmd_prot;
    logic [31:0]   cmd_seed;
    logic          done_pulse, done_error, busy;
    logic [15:0]   mismatch_count;

    axi_burst_injector_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) axi ();

    axi_burst_injector #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .QOS(4'd0)) dut (
        .aclock(aclock), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_prot(cmd_prot),
        .cmd_seed(cmd_seed), .done_pulse(done_pulse), .done_error(done_error),
        .mismatch_count(mismatch_count), .busy(busy), .axi(axi)
    );

    initial aclock = 1'b0;
    always #5 aclock = ~aclock;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [31:0] w);
        return {(DW/32){w}};
    endfunction

    // slave configuration
    int          aw_stall = 0;
    logic [1:0]  b_resp_cfg = 2'b00;
    bit          b_bad_id = 0;
    logic [31:0] r_seed = 32'h0;
    int          r_corrupt = -1, r_bad_resp = -1, r_early_last = -1;
    bit          r_bad_id = 0;

    // slave protocol state and records
    bit          aw_seen, wl_seen, b_clear, r_active, r_start, r_hs_pend, r_last_pend, aw_snap_v;
    int          r_beat;
    logic [82:0] aw_snap;
    logic [DW-1:0] w_data [16];
    logic        w_last [16];
    int          w_n, w_at_aw, aw_n, aw_unstable, r_n, w_strb_bad;
    logic [AW-1:0] aw_addr_r, ar_addr_r;
    logic [7:0]  aw_len_r, ar_len_r;
    logic [IW-1:0] aw_id_r, ar_id_r;
    logic [2:0]  aw_size_r, aw_prot_r, ar_size_r;
    logic [1:0]  aw_burst_r, ar_burst_r;
    logic [3:0]  aw_qos_r, ar_qos_r;

    task automatic clr_rec();
        w_n = 0; w_at_aw = -1; aw_n = 0; aw_unstable = 0; r_n = 0; w_strb_bad = 0;
        aw_stall = 0; b_resp_cfg = 2'b00; b_bad_id = 0;
        r_corrupt = -1; r_bad_resp = -1; r_early_last = -1; r_bad_id = 0;
    endtask

    initial begin
        axi.awready = 0; axi.wready = 0; axi.bid = '0; axi.bresp = 0; axi.bvalid = 0;
        axi.arready = 0; axi.rid = '0; axi.rdata = '0; axi.rresp = 0; axi.rlast = 0; axi.rvalid = 0;
        aw_seen = 0; wl_seen = 0; b_clear = 0; r_active = 0; r_start = 0; r_hs_pend = 0;
        r_last_pend = 0; aw_snap_v = 0; r_beat = 0; aw_snap = '0;
        forever begin
            @(negedge aclock);
            if (areset) begin
                axi.bvalid = 0; axi.rvalid = 0; axi.rlast = 0;
                axi.awready = 0; axi.wready = 0; axi.arready = 0;
                aw_seen = 0; wl_seen = 0; b_clear = 0; r_active = 0; r_start = 0;
                r_hs_pend = 0; aw_snap_v = 0;
            end else begin
                if (b_clear) begin axi.bvalid = 0; b_clear = 0; end
                if (aw_seen && wl_seen && !axi.bvalid) begin
                    axi.bvalid = 1;
                    axi.bresp  = b_resp_cfg;
                    axi.bid    = b_bad_id ? (aw_id_r ^ 24'h1) : aw_id_r;
                    aw_seen = 0; wl_seen = 0;
                end
                if (r_hs_pend) begin
                    r_n++; r_beat++;
                    if (r_last_pend) r_active = 0;
                    r_hs_pend = 0;
                end
                if (r_start) begin r_active = 1; r_beat = 0; r_start = 0; end
                if (r_active) begin
                    axi.rvalid = 1;
                    axi.rdata  = pat(r_seed + 32'(r_beat)) ^ ((r_beat == r_corrupt) ? 256'd4 : 256'd0);
                    axi.rresp  = (r_beat == r_bad_resp) ? 2'b10 : 2'b00;
                    axi.rid    = r_bad_id ? (ar_id_r ^ 24'h1) : ar_id_r;
                    axi.rlast  = (r_beat == int'(ar_len_r)) || (r_beat == r_early_last);
                end else begin
                    axi.rvalid = 0; axi.rlast = 0;
                end
                if (axi.awvalid && aw_stall > 0) begin axi.awready = 0; aw_stall--; end
                else axi.awready = 1;
                axi.wready = 1; axi.arready = 1;
                // handshakes that complete at the coming posedge
                if (axi.awvalid && aw_snap_v &&
                    aw_snap != {axi.awaddr, axi.awid, axi.awlen, axi.awprot}) aw_unstable++;
                if (axi.awvalid && axi.awready) begin
                    aw_addr_r = axi.awaddr; aw_len_r = axi.awlen; aw_id_r = axi.awid;
                    aw_size_r = axi.awsize; aw_burst_r = axi.awburst; aw_prot_r = axi.awprot;
                    aw_qos_r = axi.awqos; aw_n++; w_at_aw = w_n; aw_seen = 1; aw_snap_v = 0;
                end else if (axi.awvalid) begin
                    aw_snap = {axi.awaddr, axi.awid, axi.awlen, axi.awprot}; aw_snap_v = 1;
                end
                if (axi.wvalid && axi.wready) begin
                    if (w_n < 16) begin w_data[w_n] = axi.wdata; w_last[w_n] = axi.wlast; end
                    if (axi.wstrb != '1) w_strb_bad++;
                    w_n++;
                    if (axi.wlast) wl_seen = 1;
                end
                if (axi.bvalid && axi.bready) b_clear = 1;
                if (axi.arvalid && axi.arready) begin
                    ar_addr_r = axi.araddr; ar_len_r = axi.arlen; ar_id_r = axi.arid;
                    ar_size_r = axi.arsize; ar_burst_r = axi.arburst; ar_qos_r = axi.arqos;
                    r_start = 1;
                end
                if (axi.rvalid && axi.rready) begin r_hs_pend = 1; r_last_pend = axi.rlast; end
            end
        end
    end

    int          d_lat;
    logic        d_err;
    logic [15:0] d_mm;

    task automatic wait_done();
        d_lat = 1;
        while (!done_pulse && d_lat < 300) begin @(negedge aclock); #1; d_lat++; end
        chk("done_seen", done_pulse, 1);
        d_err = done_error;
        d_mm  = mismatch_count;
        @(negedge aclock); #1;
        chk("busy_after_done", busy, 0);
    endtask

    task automatic present(input logic wr, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                           input logic [7:0] len, input logic [31:0] seed);
        int t;
        cmd_write = wr; cmd_id = id; cmd_addr = addr; cmd_len = len;
        cmd_prot = 3'd2; cmd_seed = seed; cmd_valid = 1;
        t = 0;
        while (!cmd_ready && t < 50) begin @(negedge aclock); #1; t++; end
        chk("cmd_ready_seen", cmd_ready, 1);
        @(negedge aclock); #1;
    endtask

    task automatic issue(input logic wr, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                         input logic [7:0] len, input logic [31:0] seed);
        present(wr, id, addr, len, seed);
        cmd_valid = 0;
        chk("busy_after_accept", busy, 1);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, rdy_busy;
        logic exp_mm_err;
        areset = 1; cmd_valid = 0; cmd_write = 0; cmd_id = '0; cmd_addr = '0;
        cmd_len = '0; cmd_prot = '0; cmd_seed = '0;
        clr_rec();
`ifdef AXI_BURST_INJECTOR_READ_CHECK_EN
        exp_mm_err = 1;
`else
        exp_mm_err = 0;
`endif
        repeat (3) @(negedge aclock);
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 0);
        chk("rst_done", {done_pulse, done_error}, 0);
        chk("rst_mm", mismatch_count, 0);
        areset = 0;
        @(negedge aclock); #1;
        chk("idle_cmd_ready", cmd_ready, 1);

        // minimum latency: write len=0, done_pulse in the 4th cycle counting the accept cycle
        clr_rec();
        issue(1, 24'h1, 48'h800, 8'd0, 32'h5);
        chk("lat_w0", d_lat, 3);
        chk("lat_w0_err", d_err, 0);
        chk("lat_w0_data", w_data[0], pat(32'h5));

        // write len=3 addr 0x1000 seed 0x10 id 5
        clr_rec();
        issue(1, 24'h5, 48'h1000, 8'd3, 32'h10);
        chk("w1_beats", w_n, 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("w1_data%0d", k), w_data[k], pat(32'h10 + 32'(k)));
            chk($sformatf("w1_last%0d", k), w_last[k], (k == 3));
        end
        chk("w1_awaddr", aw_addr_r, 48'h1000);
        chk("w1_awfields", {aw_len_r, aw_id_r, aw_size_r, aw_burst_r, aw_prot_r, aw_qos_r},
            {8'd3, 24'h5, 3'd5, 2'b01, 3'd2, 4'd0});
        chk("w1_wstrb", w_strb_bad, 0);
        chk("w1_err", d_err, 0);

        // awready stalled 6 cycles: W finishes first, AW payload holds
        clr_rec();
        aw_stall = 6;
        issue(1, 24'h6, 48'h2040, 8'd3, 32'h200);
        chk("w2_w_before_aw", w_at_aw, 4);
        chk("w2_aw_stable", aw_unstable, 0);
        chk("w2_awaddr", aw_addr_r, 48'h2040);
        chk("w2_data3", w_data[3], pat(32'h203));
        chk("w2_err", d_err, 0);

        // bad write responses
        clr_rec();
        b_resp_cfg = 2'b10;
        issue(1, 24'h7, 48'h3000, 8'd1, 32'h0);
        chk("w3_slverr", d_err, 1);
        clr_rec();
        b_bad_id = 1;
        issue(1, 24'h8, 48'h3000, 8'd0, 32'h0);
        chk("w3_bid", d_err, 1);

        // clean read len=7 seed 0xA0
        clr_rec();
        r_seed = 32'hA0;
        issue(0, 24'h9, 48'h4000, 8'd7, 32'hA0);
        chk("r1_beats", r_n, 8);
        chk("r1_arfields", {ar_addr_r, ar_len_r, ar_id_r, ar_size_r, ar_burst_r, ar_qos_r},
            {48'h4000, 8'd7, 24'h9, 3'd5, 2'b01, 4'd0});
        chk("r1_mm", d_mm, 0);
        chk("r1_err", d_err, 0);

        // corrupted beat 2
        clr_rec();
        r_corrupt = 2;
        issue(0, 24'h9, 48'h4000, 8'd7, 32'hA0);
        chk("r2_mm", d_mm, {15'd0, exp_mm_err});
        chk("r2_err", d_err, exp_mm_err);

        // following clean read: count cleared on accept
        clr_rec();
        issue(0, 24'h9, 48'h4000, 8'd7, 32'hA0);
        chk("r3_mm_cleared", d_mm, 0);
        chk("r3_err", d_err, 0);

        // SLVERR on beat 0, then wrong rid
        clr_rec();
        r_bad_resp = 0;
        issue(0, 24'hA, 48'h4100, 8'd3, 32'hA0);
        chk("r4_slverr", d_err, 1);
        chk("r4_mm", d_mm, 0);
        clr_rec();
        r_bad_id = 1;
        issue(0, 24'hB, 48'h4100, 8'd3, 32'hA0);
        chk("r5_rid", d_err, 1);

        // early rlast on beat 3 of len=7
        clr_rec();
        r_early_last = 3;
        issue(0, 24'hC, 48'h4200, 8'd7, 32'hA0);
        chk("r6_beats", r_n, 4);
        chk("r6_err", d_err, 1);

        // cmd_valid held through a busy burst
        clr_rec();
        r_seed = 32'h55;
        present(0, 24'hD, 48'h5000, 8'd1, 32'h55);
        cmd_write = 1; cmd_id = 24'h7; cmd_addr = 48'h5100; cmd_len = 8'd0; cmd_seed = 32'h77;
        rdy_busy = 0; t = 0;
        while (!done_pulse && t < 100) begin
            if (cmd_ready) rdy_busy++;
            @(negedge aclock); #1; t++;
        end
        chk("b2b_done", done_pulse, 1);
        chk("b2b_rdy_busy", rdy_busy, 0);
        chk("b2b_rdy_at_done", cmd_ready, 0);
        @(negedge aclock); #1;
        chk("b2b_rdy_after", cmd_ready, 1);
        @(negedge aclock); #1;
        cmd_valid = 0;
        chk("b2b_busy2", busy, 1);
        wait_done();
        chk("b2b_err", d_err, 0);
        chk("b2b_ar", {ar_len_r, ar_id_r}, {8'd1, 24'hD});
        chk("b2b_aw", {aw_len_r, aw_id_r}, {8'd0, 24'h7});
        chk("b2b_wdata", w_data[0], pat(32'h77));

        // reset during write beat 2
        clr_rec();
        present(1, 24'h3, 48'h6000, 8'd3, 32'h100);
        cmd_valid = 0;
        t = 0;
        while (w_n < 3 && t < 20) begin @(negedge aclock); #1; t++; end
        chk("rst_reach_beat2", w_n, 3);
        areset = 1;
        @(negedge aclock); #1;
        chk("mid_rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", cmd_ready, 0);
        chk("mid_rst_done", done_pulse, 0);
        areset = 0;
        @(negedge aclock); #1;
        chk("post_rst_ready", cmd_ready, 1);
        clr_rec();
        r_seed = 32'h300;
        issue(0, 24'hE, 48'h7000, 8'd0, 32'h300);
        chk("post_rst_read_err", d_err, 0);
        chk("post_rst_read_beats", r_n, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
